// File: rtl/fp_result_check_pkg.sv
// fp_result_check_pkg: shared state, entry and error-code definitions for the fp_unit result checker
package fp_result_check_pkg;
    typedef enum logic [2:0] {
        CHK_IDLE  = 3'd0,
        CHK_RUN   = 3'd1,
        CHK_DRAIN = 3'd2,
        CHK_PASS  = 3'd3,
        CHK_FAIL  = 3'd4
    } fp_check_state_type;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        f2i;
    } fp_check_entry_type;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_MISMATCH  = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
endpackage

// File: rtl/fp_result_check_if.sv
// fp_result_check_if: expected-record push channel and fp_unit response channel seen by the checker
interface fp_result_check_if;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_result;
    logic [4:0]  push_flags;
    logic        push_f2i;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        done;

    modport master (
        output push_valid, push_result, push_flags, push_f2i,
        output rsp_ready, rsp_result, rsp_flags, done,
        input  push_ready
    );

    modport slave (
        input  push_valid, push_result, push_flags, push_f2i,
        input  rsp_ready, rsp_result, rsp_flags, done,
        output push_ready
    );
endinterface

// File: rtl/fp_result_check_fifo.sv
// fp_result_check_fifo: in-order FIFO of expected records; pointers carry an extra wrap bit for full/empty
module fp_result_check_fifo
    import fp_result_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  fp_check_entry_type wr_data,
    input  logic               rd_en,
    output fp_check_entry_type head,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);

    fp_check_entry_type mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // advance write/read pointers on accepted push/pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty = wr_ptr == rd_ptr;
    assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/fp_result_check.sv
// fp_result_check: in-order fp_unit result/flag checker with counters, first-error capture and verdict (optional watchdog: FP_CHECK_TIMEOUT_EN)
module fp_result_check
    import fp_result_check_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter bit STOP_ON_FAIL = 1'b1
`ifdef FP_CHECK_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 64
`endif
) (
    input  logic              clock,
    input  logic              reset,
    fp_result_check_if.slave  bus,
    output logic [2:0]        state,
    output logic [31:0]       pass_cnt,
    output logic [31:0]       fail_cnt,
    output logic [2:0]        err_code,
    output logic [31:0]       err_index,
    output logic [31:0]       err_exp_result,
    output logic [31:0]       err_calc_result,
    output logic [4:0]        err_exp_flags,
    output logic [4:0]        err_calc_flags
);
    fp_check_state_type state_q;
    fp_check_state_type state_d;
    fp_check_entry_type head;
    logic        full;
    logic        empty;
    logic        active;
    logic        push_en;
    logic        pop_en;
    logic        overflow;
    logic        underflow;
    logic        mismatch;
    logic        timeout;
    logic        fatal;
    logic [31:0] res_diff;
    logic [4:0]  flag_diff;
    logic [2:0]  err_new;
    logic [31:0] rsp_idx;

    fp_result_check_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push_en),
        .wr_data ('{result: bus.push_result, flags: bus.push_flags, f2i: bus.push_f2i}),
        .rd_en   (pop_en),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    // PASS/FAIL freeze everything, so all activity is qualified by active
    assign active         = state_q inside {CHK_IDLE, CHK_RUN, CHK_DRAIN};
    assign bus.push_ready = active && !full;
    assign push_en        = bus.push_valid && bus.push_ready;
    assign pop_en         = active && bus.rsp_ready && !empty;
    assign overflow       = active && bus.push_valid && full;
    assign underflow      = active && bus.rsp_ready && empty;

    // a canonical NaN from a non-convert op only has to agree on exponent and quiet bit
    assign res_diff  = (!head.f2i && bus.rsp_result == FP_CANON_NAN)
                     ? {1'b0, bus.rsp_result[30:22] ^ head.result[30:22], 22'h0}
                     : bus.rsp_result ^ head.result;
    assign flag_diff = bus.rsp_flags ^ head.flags;
    assign mismatch  = pop_en && (res_diff != '0 || flag_diff != '0);

    assign err_new = mismatch  ? ERR_MISMATCH  :
                     overflow  ? ERR_OVERFLOW  :
                     underflow ? ERR_UNDERFLOW :
                     timeout   ? ERR_TIMEOUT   : ERR_NONE;
    assign fatal   = overflow || underflow || timeout || (mismatch && STOP_ON_FAIL);

`ifdef FP_CHECK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_q;

    // count stalled cycles while a response is owed; any response restarts the count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) wd_q <= '0;
        else if (!active || empty || bus.rsp_ready) wd_q <= '0;
        else if (wd_q != WD_MAX) wd_q <= wd_q + 1'b1;
    end

    assign timeout = (state_q == CHK_RUN || state_q == CHK_DRAIN) && wd_q == WD_MAX;
`else
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= CHK_IDLE;
        else state_q <= state_d;
    end

    // verdict sequencing; PASS and FAIL hold until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            CHK_IDLE:  state_d = fatal ? CHK_FAIL : push_en ? CHK_RUN : bus.done ? CHK_DRAIN : CHK_IDLE;
            CHK_RUN:   state_d = fatal ? CHK_FAIL : bus.done ? CHK_DRAIN : CHK_RUN;
            CHK_DRAIN: state_d = fatal ? CHK_FAIL : !empty ? CHK_DRAIN : fail_cnt != '0 ? CHK_FAIL : CHK_PASS;
            default:   state_d = state_q;
        endcase
    end

    assign state = state_q;

    // saturating counters, response index and first-error capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            rsp_idx         <= '0;
            err_code        <= ERR_NONE;
            err_index       <= '0;
            err_exp_result  <= '0;
            err_calc_result <= '0;
            err_exp_flags   <= '0;
            err_calc_flags  <= '0;
        end else begin
            if (pop_en && !mismatch && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            if (mismatch && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            if (pop_en && rsp_idx != '1) rsp_idx <= rsp_idx + 1'b1;
            if (err_code == ERR_NONE && err_new != ERR_NONE) begin
                err_code  <= err_new;
                err_index <= rsp_idx;
                if (mismatch) begin
                    err_exp_result  <= head.result;
                    err_calc_result <= bus.rsp_result;
                    err_exp_flags   <= head.flags;
                    err_calc_flags  <= bus.rsp_flags;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_result_check.sv
// tb_fp_result_check: table vectors, corner sequences and randomized runs against a rule-level model
module tb_fp_result_check;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] exp_result;
        logic [4:0]  exp_flags;
        logic        f2i;
        logic [31:0] calc_result;
        logic [4:0]  calc_flags;
        bit          match;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  state;
    logic [31:0] pass_cnt;
    logic [31:0] fail_cnt;
    logic [2:0]  err_code;
    logic [31:0] err_index;
    logic [31:0] err_exp_result;
    logic [31:0] err_calc_result;
    logic [4:0]  err_exp_flags;
    logic [4:0]  err_calc_flags;

    int checks = 0;
    int errors = 0;

    fp_result_check_if bus ();

    fp_result_check #(.DEPTH(DEPTH), .STOP_ON_FAIL(1'b1)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .state           (state),
        .pass_cnt        (pass_cnt),
        .fail_cnt        (fail_cnt),
        .err_code        (err_code),
        .err_index       (err_index),
        .err_exp_result  (err_exp_result),
        .err_calc_result (err_calc_result),
        .err_exp_flags   (err_exp_flags),
        .err_calc_flags  (err_calc_flags)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.push_valid  = 1'b0;
        bus.push_result = '0;
        bus.push_flags  = '0;
        bus.push_f2i    = 1'b0;
        bus.rsp_ready   = 1'b0;
        bus.rsp_result  = '0;
        bus.rsp_flags   = '0;
        bus.done        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic set_push(input logic [31:0] r, input logic [4:0] f, input logic x);
        bus.push_valid  = 1'b1;
        bus.push_result = r;
        bus.push_flags  = f;
        bus.push_f2i    = x;
    endtask

    task automatic set_rsp(input logic [31:0] r, input logic [4:0] f);
        bus.rsp_ready  = 1'b1;
        bus.rsp_result = r;
        bus.rsp_flags  = f;
    endtask

    // a result is acceptable when flags agree and either the values are identical, or a
    // non-convert op returned the canonical NaN where any quiet NaN was expected
    function automatic bit model_match(input vec_t v);
        bit exp_qnan;
        exp_qnan = v.exp_result[30:23] == 8'hFF && v.exp_result[22];
        if (v.calc_flags != v.exp_flags) return 1'b0;
        if (!v.f2i && v.calc_result == 32'h7FC00000) return exp_qnan;
        return v.calc_result == v.exp_result;
    endfunction

    function automatic vec_t gen_vec();
        vec_t v;
        int kind;
        kind = $urandom_range(0, 3);
        v.exp_result = $urandom;
        v.exp_flags  = 5'($urandom);
        v.f2i        = kind == 2;
        if (kind == 1) v.exp_result[30:22] = 9'h1FF;
        if (kind == 3) v.exp_result = 32'h7FC00000;
        v.calc_result = kind == 1 ? 32'h7FC00000 : v.exp_result;
        v.calc_flags  = v.exp_flags;
        if ($urandom_range(0, 24) == 0) begin
            case ($urandom_range(0, 2))
                0:       v.calc_result = v.calc_result ^ (32'd1 << $urandom_range(0, 31));
                1:       v.calc_flags  = v.calc_flags ^ 5'(1 << $urandom_range(0, 4));
                default: v.f2i = ~v.f2i;
            endcase
        end
        v.match = 1'b0;
        return v;
    endfunction

    vec_t tbl [11];
    vec_t q[$];
    vec_t v;
    vec_t bad;
    int   issued;
    int   m_pass;
    int   bad_idx;
    int   occ;
    bit   failed;

    initial begin
        tbl[0]  = '{32'h3F800000, 5'h00, 1'b0, 32'h3F800000, 5'h00, 1'b1};
        tbl[1]  = '{32'h3F800000, 5'h00, 1'b0, 32'h3F800000, 5'h01, 1'b0};
        tbl[2]  = '{32'hFFC00001, 5'h00, 1'b0, 32'h7FC00000, 5'h00, 1'b1};
        tbl[3]  = '{32'hFFC00001, 5'h00, 1'b1, 32'h7FC00000, 5'h00, 1'b0};
        tbl[4]  = '{32'h7FC00000, 5'h10, 1'b0, 32'h7FC00000, 5'h10, 1'b1};
        tbl[5]  = '{32'h7F800001, 5'h00, 1'b0, 32'h7FC00000, 5'h00, 1'b0};
        tbl[6]  = '{32'h7FE00000, 5'h00, 1'b0, 32'h7FC00000, 5'h00, 1'b1};
        tbl[7]  = '{32'h7FC00000, 5'h00, 1'b0, 32'h7FC00001, 5'h00, 1'b0};
        tbl[8]  = '{32'h80000000, 5'h00, 1'b0, 32'h00000000, 5'h00, 1'b0};
        tbl[9]  = '{32'h7FFFFFFF, 5'h04, 1'b1, 32'h7FFFFFFF, 5'h04, 1'b1};
        tbl[10] = '{32'hFFC00000, 5'h00, 1'b0, 32'h7FC00000, 5'h10, 1'b0};

        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
        chk("rst_pass_cnt", pass_cnt, 32'd0);
        chk("rst_fail_cnt", fail_cnt, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_err_index", err_index, 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_push(tbl[i].exp_result, tbl[i].exp_flags, tbl[i].f2i);
            tick();
            bus.push_valid = 1'b0;
            set_rsp(tbl[i].calc_result, tbl[i].calc_flags);
            tick();
            bus.rsp_ready = 1'b0;
            chk($sformatf("tbl%0d_pass", i), pass_cnt, tbl[i].match ? 32'd1 : 32'd0);
            chk($sformatf("tbl%0d_fail", i), fail_cnt, tbl[i].match ? 32'd0 : 32'd1);
            chk($sformatf("tbl%0d_state", i), 32'(state), tbl[i].match ? 32'd1 : 32'd4);
            chk($sformatf("tbl%0d_err_code", i), 32'(err_code), tbl[i].match ? 32'd0 : 32'd1);
        end

        // three records, responses two cycles behind, then done
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c == 0) set_push(32'h3F800000, 5'h00, 1'b0);
            if (c == 1) set_push(32'h40000000, 5'h00, 1'b0);
            if (c == 2) set_push(32'h7FC00000, 5'h10, 1'b0);
            if (c == 2) set_rsp(32'h3F800000, 5'h00);
            if (c == 3) set_rsp(32'h40000000, 5'h00);
            if (c == 4) set_rsp(32'h7FC00000, 5'h10);
            tick();
            if (c == 0) chk("seq3_run", 32'(state), 32'd1);
        end
        idle_inputs();
        bus.done = 1'b1;
        tick();
        chk("seq3_drain", 32'(state), 32'd2);
        tick();
        chk("seq3_state", 32'(state), 32'd3);
        chk("seq3_pass", pass_cnt, 32'd3);
        chk("seq3_fail", fail_cnt, 32'd0);
        chk("seq3_push_ready", 32'(bus.push_ready), 32'd0);

        // flag-only mismatch: capture and freeze
        do_reset();
        set_push(32'h3F800000, 5'h00, 1'b0);
        tick();
        idle_inputs();
        set_rsp(32'h3F800000, 5'h01);
        tick();
        idle_inputs();
        chk("flag_state", 32'(state), 32'd4);
        chk("flag_err_code", 32'(err_code), 32'd1);
        chk("flag_err_index", err_index, 32'd0);
        chk("flag_err_exp_flags", 32'(err_exp_flags), 32'h00);
        chk("flag_err_calc_flags", 32'(err_calc_flags), 32'h01);
        chk("flag_err_exp_result", err_exp_result, 32'h3F800000);
        set_push(32'h1, 5'h0, 1'b0);
        set_rsp(32'h3F800000, 5'h00);
        tick();
        idle_inputs();
        chk("frozen_pass", pass_cnt, 32'd0);
        chk("frozen_fail", fail_cnt, 32'd1);
        chk("frozen_push_ready", 32'(bus.push_ready), 32'd0);

        // second response is an f2i NaN mismatch
        do_reset();
        set_push(32'h3F800000, 5'h00, 1'b0);
        tick();
        set_push(32'hFFC00001, 5'h00, 1'b1);
        set_rsp(32'h3F800000, 5'h00);
        tick();
        idle_inputs();
        set_rsp(32'h7FC00000, 5'h00);
        tick();
        idle_inputs();
        chk("f2i_err_code", 32'(err_code), 32'd1);
        chk("f2i_err_index", err_index, 32'd1);
        chk("f2i_err_calc", err_calc_result, 32'h7FC00000);
        chk("f2i_err_exp", err_exp_result, 32'hFFC00001);
        chk("f2i_pass", pass_cnt, 32'd1);

        // overflow with a simultaneous pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_push(32'(i), 5'h00, 1'b1);
            tick();
        end
        idle_inputs();
        chk("full_push_ready", 32'(bus.push_ready), 32'd0);
        set_push(32'h55, 5'h00, 1'b1);
        set_rsp(32'h0, 5'h00);
        tick();
        idle_inputs();
        chk("ovf_err_code", 32'(err_code), 32'd2);
        chk("ovf_state", 32'(state), 32'd4);
        chk("ovf_pass", pass_cnt, 32'd1);

        // underflow even with a simultaneous push
        do_reset();
        set_push(32'h3F800000, 5'h00, 1'b0);
        set_rsp(32'h3F800000, 5'h00);
        tick();
        idle_inputs();
        chk("unf_err_code", 32'(err_code), 32'd3);
        chk("unf_state", 32'(state), 32'd4);
        chk("unf_pass", pass_cnt, 32'd0);

        // done with nothing pushed
        do_reset();
        bus.done = 1'b1;
        tick();
        chk("empty_done_drain", 32'(state), 32'd2);
        tick();
        chk("empty_done_pass", 32'(state), 32'd3);

        // asynchronous reset mid-run
        do_reset();
        set_push(32'h1, 5'h0, 1'b1);
        tick();
        set_push(32'h2, 5'h0, 1'b1);
        set_rsp(32'h1, 5'h0);
        tick();
        idle_inputs();
        chk("mid_pass_before", pass_cnt, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_pass", pass_cnt, 32'd0);
        chk("mid_rst_push_ready", 32'(bus.push_ready), 32'd1);

`ifdef FP_CHECK_TIMEOUT_EN
        do_reset();
        set_push(32'h3F800000, 5'h00, 1'b0);
        tick();
        idle_inputs();
        repeat (66) tick();
        chk("to_err_code", 32'(err_code), 32'd4);
        chk("to_state", 32'(state), 32'd4);
        chk("to_err_index", err_index, 32'd0);

        do_reset();
        set_push(32'h3F800000, 5'h00, 1'b0);
        tick();
        idle_inputs();
        repeat (62) tick();
        set_rsp(32'h3F800000, 5'h00);
        tick();
        idle_inputs();
        bus.done = 1'b1;
        repeat (3) tick();
        chk("late_rsp_state", 32'(state), 32'd3);
        chk("late_rsp_err_code", 32'(err_code), 32'd0);
`endif

        // randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            q.delete();
            issued  = 0;
            m_pass  = 0;
            bad_idx = 0;
            failed  = 1'b0;
            for (int cyc = 0; cyc < 400 && !failed && (issued < 40 || q.size() > 0); cyc++) begin
                idle_inputs();
                occ = q.size();
                if (occ > 0 && $urandom_range(0, 2) != 0) begin
                    v = q.pop_front();
                    set_rsp(v.calc_result, v.calc_flags);
                    if (model_match(v)) m_pass++;
                    else begin
                        failed  = 1'b1;
                        bad     = v;
                        bad_idx = m_pass;
                    end
                end
                if (issued < 40 && occ < DEPTH && $urandom_range(0, 1) == 1) begin
                    v = gen_vec();
                    set_push(v.exp_result, v.exp_flags, v.f2i);
                    q.push_back(v);
                    issued++;
                end
                tick();
            end
            idle_inputs();
            bus.done = !failed;
            repeat (3) tick();
            chk($sformatf("rnd%0d_state", r), 32'(state), failed ? 32'd4 : 32'd3);
            chk($sformatf("rnd%0d_pass", r), pass_cnt, 32'(m_pass));
            chk($sformatf("rnd%0d_fail", r), fail_cnt, failed ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_err_code", r), 32'(err_code), failed ? 32'd1 : 32'd0);
            if (failed) begin
                chk($sformatf("rnd%0d_err_index", r), err_index, 32'(bad_idx));
                chk($sformatf("rnd%0d_err_exp", r), err_exp_result, bad.exp_result);
                chk($sformatf("rnd%0d_err_calc", r), err_calc_result, bad.calc_result);
                chk($sformatf("rnd%0d_err_eflags", r), 32'(err_exp_flags), 32'(bad.exp_flags));
                chk($sformatf("rnd%0d_err_cflags", r), 32'(err_calc_flags), 32'(bad.calc_flags));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_result_check.md
Name: fp_result_check

Overview:
- Synthesizable response-side checker for fp_unit; consumes the result stream the vector driver provokes.
- The driver pushes the expected record for each issued op into an in-order FIFO.
- Each fp_unit ready pulse pops the head entry and compares result and flags, with canonical-NaN masking for non-convert ops.
- Keeps pass/fail counts, latches the first failure, and reports a final verdict. Lets FPGA/emulation runs self-check without a simulator.

Parameters:
- DEPTH, 8, expected-record FIFO entries (power of two, ≥ pipeline depth + 1).
- STOP_ON_FAIL, 1, 1 = go to FAIL on the first mismatch; 0 = keep counting, verdict at drain.
- TIMEOUT, 64, cycles without a response while FIFO is non-empty (used only with the optional feature).

Ports:
- reset  in  1  asynchronous, active-low
- clock  in  1  single clock
- push_valid  in  1  expected record valid (issue time)
- push_ready  out  1  FIFO not full
- push_result  in  32  expected result
- push_flags  in  5  expected fflags
- push_f2i  in  1  op is fcvt_f2i (NaN masking disabled)
- rsp_ready  in  1  fp_unit_o.fp_exe_o.ready
- rsp_result  in  32  calculated result
- rsp_flags  in  5  calculated flags
- done  in  1  driver has issued its last vector (level)
- state  out  3  IDLE=0, RUN=1, DRAIN=2, PASS=3, FAIL=4
- pass_cnt  out  32  matched responses
- fail_cnt  out  32  mismatched responses
- err_code  out  3  0 none, 1 mismatch, 2 overflow, 3 underflow, 4 timeout
- err_index  out  32  response index (0-based) of first error
- err_exp_result / err_calc_result  out  32 each  first-failure captures
- err_exp_flags / err_calc_flags  out  5 each  first-failure captures

Behaviour:
- Reset values (async, reset low): state=IDLE, FIFO empty, all counters, err_* and index counter = 0; push_ready=1.
- Push: an entry is written when push_valid && push_ready.
  - push_valid while full raises overflow (err_code=2) → FAIL. This holds even if a pop occurs in the same cycle, because push_ready does not depend on rsp_ready.
- Compare: combinational against the FIFO head; the result is registered 1 cycle after rsp_ready.
  - No bypass: an rsp_ready with an empty FIFO is underflow (err_code=3) even if a push occurs in the same cycle.
  - Simultaneous push and pop with a non-empty, non-full FIFO both proceed; occupancy is unchanged.
- Difference rule: if !f2i && calc==32'h7FC00000, diff = {1'b0, calc[30:22]^exp[30:22], 22'h0}; else diff = calc^exp. flag diff = calc_flags^exp_flags.
  - Match when both diffs are zero: pass_cnt++.
  - Otherwise fail_cnt++. On the first error only, capture err_* and err_index (the response index counter value), then set err_code=1.
- Counters saturate at 32'hFFFFFFFF.
- State transitions:
  - IDLE → RUN on the first accepted push.
  - RUN → FAIL on any error (a mismatch only when STOP_ON_FAIL=1).
  - RUN → DRAIN when done=1.
  - DRAIN → PASS when FIFO empty and fail_cnt=0; → FAIL when FIFO empty and fail_cnt≠0, or on any error.
  - PASS and FAIL are sticky until reset.
  - IDLE → DRAIN if done is asserted with nothing pushed, then → PASS.
- In PASS/FAIL: pushes and responses are ignored, counters and captures freeze, push_ready=0.
- Reset mid-run: everything returns to reset values immediately; in-flight responses are simply not checked.

Optional Feature:
- FP_CHECK_TIMEOUT_EN
  - Defined: a watchdog counts cycles with FIFO non-empty and rsp_ready=0, and clears on each response. When it reaches TIMEOUT in RUN/DRAIN: err_code=4, err_index = current index, state → FAIL.
  - Undefined: no counter; err_code 4 never occurs; TIMEOUT is unused.

Decomposition:
- fp_wire package gains:
  - fp_check_state_type enum
  - fp_check_entry_type struct {result, flags, f2i}
  - err code localparams
  - FP_CANON_NAN = 32'h7FC00000
- Sub-module fp_check_fifo: parameterised synchronous FIFO of fp_check_entry_type. Outputs head, full, empty; pointers wrap modulo DEPTH with an extra wrap bit for full/empty.

Test Plan:
- Push 3 records (3F800000/00, 40000000/00, 7FC00000/10), matching responses 2 cycles later, then done → pass_cnt=3, fail_cnt=0, state=PASS.
- Expected FFC00001, !f2i, calc 7FC00000 → match. Same pair with push_f2i=1 → mismatch, err_code=1, err_calc_result=7FC00000.
- Expected 3F800000/00, calc 3F800000/01, STOP_ON_FAIL=1 → FAIL next cycle, err_exp_flags=00000, err_calc_flags=00001, err_index=0.
- Fill 8 entries, then push again with rsp_ready high in the same cycle → err_code=2, FAIL.
- rsp_ready with empty FIFO and a simultaneous push → err_code=3; pass_cnt stays 0.
- FP_CHECK_TIMEOUT_EN, TIMEOUT=64: push 1, no response for 64 cycles → err_code=4, FAIL. A response at cycle 63 → PASS after done.
